// File: rtl/spi_tx_pkg.sv
// rtl/spi_tx_pkg.sv - shared state encodings and default constants for the SPI TX packetizer
package spi_tx_pkg;

    localparam int FIFO_DEPTH_DEF  = 16;
    localparam int BURST_MAX_DEF   = 64;
    localparam int RDY_TIMEOUT_DEF = 1024;
    localparam int SS_HOLD_DEF     = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } tx_state_t;

    typedef enum logic [1:0] {
        SPL_EMPTY,
        SPL_HIGH,
        SPL_LOW
    } split_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with combinational head and occupancy count
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/spi_tx_packetizer.sv
// rtl/spi_tx_packetizer.sv - splits 16-bit words into bytes and drives framed SPI bursts
module spi_tx_packetizer
    import spi_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int BURST_MAX   = BURST_MAX_DEF,
    parameter int RDY_TIMEOUT = RDY_TIMEOUT_DEF,
    parameter int SS_HOLD     = SS_HOLD_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   word_in,
    input  logic                          word_valid,
    output logic                          word_ready,
    input  logic                          tx_enable,
    input  logic                          spi_busy,
    input  logic                          spi_chip_rdy,
    output logic                          spi_start,
    output logic [7:0]                    spi_data_in,
    output logic                          ss,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          burst_done,
    output logic                          rdy_timeout
);

    localparam int TW = $clog2(RDY_TIMEOUT) + 1;
    // The IDLE cycle that precedes a new frame is the last ss-high cycle
    localparam int HOLD_CYCLES = (SS_HOLD > 1) ? SS_HOLD - 1 : 1;

    split_state_t spl_state;
    logic [15:0]  hold_word;
    logic         fifo_push;
    logic [7:0]   fifo_push_data;
    logic         fifo_pop;
    logic [7:0]   fifo_head;
    logic         fifo_full;
    logic         fifo_empty;

    tx_state_t    state;
    tx_state_t    state_d;
    logic         ss_d;
    logic         start_d;
    logic [7:0]   data_d;
    logic         done_d;
    logic         tmo_d;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_d;
    logic [7:0]   byte_cnt;
    logic [7:0]   byte_cnt_d;
    logic [7:0]   hold_cnt;
    logic [7:0]   hold_cnt_d;

    assign word_ready     = (spl_state == SPL_EMPTY);
    assign fifo_push      = (spl_state != SPL_EMPTY) && !fifo_full;
    assign fifo_push_data = (spl_state == SPL_HIGH) ? hold_word[15:8] : hold_word[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spl_state <= SPL_EMPTY;
            hold_word <= '0;
        end else begin
            case (spl_state)
                SPL_EMPTY: begin
                    if (word_valid) begin
                        hold_word <= word_in;
                        spl_state <= SPL_HIGH;
                    end
                end
                SPL_HIGH: begin
                    if (!fifo_full) begin
                        spl_state <= SPL_LOW;
                    end
                end
                SPL_LOW: begin
                    if (!fifo_full) begin
                        spl_state <= SPL_EMPTY;
                    end
                end
                default: spl_state <= SPL_EMPTY;
            endcase
        end
    end

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ss          <= 1'b1;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
            burst_done  <= 1'b0;
            rdy_timeout <= 1'b0;
            timer       <= '0;
            byte_cnt    <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_d;
            ss          <= ss_d;
            spi_start   <= start_d;
            spi_data_in <= data_d;
            burst_done  <= done_d;
            rdy_timeout <= tmo_d;
            timer       <= timer_d;
            byte_cnt    <= byte_cnt_d;
            hold_cnt    <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        ss_d       = ss;
        start_d    = 1'b0;
        data_d     = spi_data_in;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        timer_d    = timer;
        byte_cnt_d = byte_cnt;
        hold_cnt_d = hold_cnt;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (tx_enable && !fifo_empty) begin
                    ss_d       = 1'b0;
                    timer_d    = '0;
                    byte_cnt_d = '0;
                    state_d    = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (spi_chip_rdy) begin
                    state_d = START;
                end else if (timer == TW'(RDY_TIMEOUT - 1)) begin
                    ss_d       = 1'b1;
                    tmo_d      = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            // Only entered with the FIFO non-empty, so the pop is always real
            START: begin
                data_d     = fifo_head;
                fifo_pop   = 1'b1;
                start_d    = 1'b1;
                byte_cnt_d = byte_cnt + 1'b1;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (spi_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!spi_busy) begin
                    if (tx_enable && !fifo_empty && (byte_cnt < 8'(BURST_MAX))) begin
                        state_d = START;
                    end else begin
                        ss_d       = 1'b1;
                        done_d     = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == 8'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            default: begin
                ss_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_tx_packetizer.sv
// tb/tb_spi_tx_packetizer.sv - randomized self-checking bench for spi_tx_packetizer
module tb_spi_tx_packetizer;

    localparam int FD = 16;
    localparam int BM = 64;
    localparam int RT = 1024;
    localparam int SH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        tx_enable;
    logic        spi_busy;
    logic        spi_chip_rdy;
    logic        spi_start;
    logic [7:0]  spi_data_in;
    logic        ss;
    logic [4:0]  fifo_count;
    logic        burst_done;
    logic        rdy_timeout;

    spi_tx_packetizer #(
        .FIFO_DEPTH (FD),
        .BURST_MAX  (BM),
        .RDY_TIMEOUT(RT),
        .SS_HOLD    (SH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .tx_enable   (tx_enable),
        .spi_busy    (spi_busy),
        .spi_chip_rdy(spi_chip_rdy),
        .spi_start   (spi_start),
        .spi_data_in (spi_data_in),
        .ss          (ss),
        .fifo_count  (fifo_count),
        .burst_done  (burst_done),
        .rdy_timeout (rdy_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected byte stream: every accepted word contributes high byte then low byte
    logic [7:0] exp_q[$];
    int         rd_idx    = 0;
    int         mon_err   = 0;
    int         start_cnt = 0;
    int         done_cnt  = 0;
    int         tmo_cnt   = 0;
    int         frame_q[$];
    int         gap_q[$];
    int         cur_bytes = 0;
    int         low_len   = 0;
    int         high_len  = 0;
    int         last_low  = 0;
    logic       prev_ss   = 1'b1;
    int         busy_len  = 16;
    int         busy_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame monitor plus a spi_master busy model that answers each start pulse
    initial begin
        spi_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                start_cnt++;
                cur_bytes++;
                if (ss !== 1'b0) mon_err++;
                if (rd_idx < exp_q.size()) begin
                    if (spi_data_in !== exp_q[rd_idx]) mon_err++;
                    rd_idx++;
                end else begin
                    mon_err++;
                end
            end
            if (burst_done) done_cnt++;
            if (rdy_timeout) tmo_cnt++;
            if (!ss) begin
                if (prev_ss) begin
                    gap_q.push_back(high_len);
                    low_len = 0;
                end
                low_len++;
            end else begin
                if (!prev_ss) begin
                    frame_q.push_back(cur_bytes);
                    last_low  = low_len;
                    cur_bytes = 0;
                    high_len  = 0;
                end
                high_len++;
            end
            prev_ss = ss;
            if (!rst) begin
                spi_busy  = 1'b0;
                busy_left = 0;
            end else if (spi_start) begin
                spi_busy  = 1'b1;
                busy_left = busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) spi_busy = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        int n;
        n = 0;
        word_in    = w;
        word_valid = 1'b1;
        while (!word_ready && n < 5000) begin
            tick();
            n++;
        end
        check("push_accept", word_ready, 1'b1);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        tick();
        word_valid = 1'b0;
    endtask

    task automatic wait_fifo(input string tag, input int target);
        int n;
        n = 0;
        while (fifo_count != 5'(target) && n < 200) begin
            tick();
            n++;
        end
        check(tag, fifo_count, target);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(ss && rd_idx == exp_q.size()) && n < 20000) begin
            tick();
            n++;
        end
        repeat (6) tick();
        check(tag, exp_q.size() - rd_idx, 0);
        check({tag, "_fifo"}, fifo_count, 0);
    endtask

    initial begin
        int s0, d0, t0, f0, g0, n, nw, sum, maxf;
        rst          = 1'b0;
        word_in      = '0;
        word_valid   = 1'b0;
        tx_enable    = 1'b0;
        spi_chip_rdy = 1'b0;
        repeat (3) tick();
        check("rst_ss", ss, 1'b1);
        check("rst_start", spi_start, 1'b0);
        check("rst_data", spi_data_in, 8'h00);
        check("rst_ready", word_ready, 1'b1);
        check("rst_done", burst_done, 1'b0);
        check("rst_tmo", rdy_timeout, 1'b0);
        check("rst_count", fifo_count, 0);
        rst = 1'b1;
        tick();

        // Two fixed words, latency from IDLE, one frame of four bytes
        spi_chip_rdy = 1'b1;
        busy_len = 16;
        s0 = start_cnt; d0 = done_cnt; f0 = frame_q.size();
        push_word(16'hA1B2);
        push_word(16'hC3D4);
        wait_fifo("t1_fill", 4);
        tx_enable = 1'b1;
        @(posedge clk); #1;
        check("lat_ss_c1", ss, 1'b0);
        @(posedge clk); #1;
        check("lat_start_c2", spi_start, 1'b0);
        @(posedge clk); #1;
        check("lat_start_c3", spi_start, 1'b1);
        check("lat_data_c3", spi_data_in, 8'hA1);
        drain("t1_drain");
        check("t1_starts", start_cnt - s0, 4);
        check("t1_done", done_cnt - d0, 1);
        check("t1_frames", frame_q.size() - f0, 1);
        check("t1_frame_len", (frame_q.size() > f0) ? frame_q[f0] : -1, 4);
        check("t1_bytes", mon_err, 0);

        // tx_enable dropped during the second byte
        tx_enable = 1'b0;
        push_word(16'($urandom));
        push_word(16'($urandom));
        wait_fifo("t2_fill", 4);
        s0 = start_cnt; d0 = done_cnt; f0 = frame_q.size();
        tx_enable = 1'b1;
        n = 0;
        while (start_cnt - s0 < 2 && n < 500) begin tick(); n++; end
        tx_enable = 1'b0;
        n = 0;
        while (!ss && n < 500) begin tick(); n++; end
        repeat (6) tick();
        check("t2_starts", start_cnt - s0, 2);
        check("t2_done", done_cnt - d0, 1);
        check("t2_frame_len", (frame_q.size() > f0) ? frame_q[f0] : -1, 2);
        check("t2_count", fifo_count, 2);
        tx_enable = 1'b1;
        drain("t2_drain");
        check("t2_frame2_len", (frame_q.size() > f0 + 1) ? frame_q[f0 + 1] : -1, 2);
        check("t2_bytes", mon_err, 0);

        // chip_rdy never arrives
        tx_enable = 1'b0;
        spi_chip_rdy = 1'b0;
        push_word(16'($urandom));
        wait_fifo("t3_fill", 2);
        s0 = start_cnt; d0 = done_cnt; t0 = tmo_cnt;
        tx_enable = 1'b1;
        n = 0;
        while (ss && n < 20) begin tick(); n++; end
        n = 0;
        while (!ss && n < 2000) begin tick(); n++; end
        tx_enable = 1'b0;
        repeat (6) tick();
        check("t3_low_len", last_low, RT);
        check("t3_tmo", tmo_cnt - t0, 1);
        check("t3_count", fifo_count, 2);
        check("t3_starts", start_cnt - s0, 0);
        check("t3_done", done_cnt - d0, 0);
        spi_chip_rdy = 1'b1;
        tx_enable = 1'b1;
        drain("t3_drain");
        check("t3_bytes", mon_err, 0);

        // Fill to full, hold a 9th word, then stream past BURST_MAX across pointer wrap
        tx_enable = 1'b0;
        busy_len = $urandom_range(2, 12);
        f0 = frame_q.size(); g0 = gap_q.size(); d0 = done_cnt;
        for (int i = 0; i < 8; i++) push_word(16'($urandom));
        wait_fifo("t4_full", FD);
        push_word(16'($urandom));
        repeat (4) tick();
        check("t4_ready_low", word_ready, 1'b0);
        check("t4_still_full", fifo_count, FD);
        tx_enable = 1'b1;
        for (int i = 0; i < 26; i++) push_word(16'($urandom));
        drain("t4_drain");
        check("t4_frames", frame_q.size() - f0, 2);
        check("t4_frame1", (frame_q.size() > f0) ? frame_q[f0] : -1, BM);
        check("t4_frame2", (frame_q.size() > f0 + 1) ? frame_q[f0 + 1] : -1, 70 - BM);
        check("t4_gap", (gap_q.size() > g0 + 1) ? gap_q[g0 + 1] : -1, SH);
        check("t4_done", done_cnt - d0, 2);
        check("t4_bytes", mon_err, 0);

        // Random words, gaps and busy lengths
        for (int r = 0; r < 4; r++) begin
            busy_len = $urandom_range(1, 20);
            nw = $urandom_range(1, 12);
            f0 = frame_q.size();
            tx_enable = 1'b1;
            for (int i = 0; i < nw; i++) begin
                push_word(16'($urandom));
                repeat ($urandom_range(0, 25)) tick();
            end
            drain("rand_drain");
            sum = 0;
            maxf = 0;
            for (int k = f0; k < frame_q.size(); k++) begin
                sum += frame_q[k];
                if (frame_q[k] > maxf) maxf = frame_q[k];
            end
            check("rand_total", sum, 2 * nw);
            check("rand_frame_max", maxf <= BM, 1'b1);
            check("rand_bytes", mon_err, 0);
        end

        // Reset while spi_master is busy mid-frame
        busy_len = 16;
        tx_enable = 1'b1;
        for (int i = 0; i < 3; i++) push_word(16'($urandom));
        n = 0;
        while (!spi_busy && n < 200) begin tick(); n++; end
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rstm_ss", ss, 1'b1);
        check("rstm_start", spi_start, 1'b0);
        while (exp_q.size() > rd_idx) void'(exp_q.pop_back());
        tick();
        tick();
        tx_enable = 1'b0;
        rst = 1'b1;
        tick();
        check("rstm_count", fifo_count, 0);
        check("rstm_ready", word_ready, 1'b1);
        tx_enable = 1'b1;
        push_word(16'h5AA5);
        drain("rstm_drain");
        check("rstm_bytes", mon_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
